simon_sequence_player: RTL

Upstream stage of the colour encoder: generates and replays the game's colour sequence. Each `start` appends one pseudo-random colour to an internal sequence of up to MAX_LEN entries, then plays the whole sequence as timed ON/OFF flashes on a 2-bit colour code (00 red, 01 blue, 10 yellow, 11 green). The encoder consumes `colour_out` directly. `colour_valid` gates the lamp drivers. A read port lets the input checker compare player presses against stored entries.

---
 rtl/simon_sequence_player_pkg.sv | 23 ++
 rtl/simon_sequence_player_if.sv | 30 +++
 rtl/simon_sequence_player_lfsr8.sv | 21 ++
 rtl/simon_sequence_player.sv | 124 ++++++++++++
 4 files changed

// File: rtl/simon_sequence_player_pkg.sv
// Shared colour codes, FSM state encoding and the LFSR step used by the
// Simon sequence player.
package simon_pkg;

    localparam logic [1:0] COL_RED    = 2'b00;
    localparam logic [1:0] COL_BLUE   = 2'b01;
    localparam logic [1:0] COL_YELLOW = 2'b10;
    localparam logic [1:0] COL_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        APPEND,
        ON,
        OFF,
        DONE
    } state_t;

    // Fibonacci step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

endpackage

// File: rtl/simon_sequence_player_if.sv
// Control, playback and read-port signals between the sequence player
// (slave) and the game logic that drives it (master).
interface simon_sequence_player_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    logic             start;
    logic             clear;
    logic [1:0]       colour_out;
    logic             colour_valid;
    logic             busy;
    logic             done;
    logic             full;
    logic [LEN_W-1:0] seq_len;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_colour;

    modport master (
        output start, clear, rd_idx,
        input  colour_out, colour_valid, busy, done, full, seq_len, rd_colour
    );

    modport slave (
        input  start, clear, rd_idx,
        output colour_out, colour_valid, busy, done, full, seq_len, rd_colour
    );

endinterface

// File: rtl/simon_sequence_player_lfsr8.sv
// Free-running 8-bit LFSR; the player samples its low bits whenever a new
// colour is appended, so press timing decides the colour.
module lfsr8
    import simon_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/simon_sequence_player.sv
// Simon colour sequence player: appends one random colour per round and
// replays the stored sequence as timed ON/OFF flashes.
module simon_sequence_player
    import simon_pkg::*;
#(
    parameter int         MAX_LEN   = 16,
    parameter int         ON_TICKS  = 4,
    parameter int         OFF_TICKS = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    simon_sequence_player_if.slave  bus
);

    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int IDX_W    = $clog2(MAX_LEN);
    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [LEN_W-1:0]  seq_len_q, seq_len_d;
    logic [1:0]        mem_q [MAX_LEN];
    logic [7:0]        lfsr_q;
    logic              wr_en;
    logic              full_w;
    logic              last_w;
    logic              unused_lfsr_bits;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[7:2];
    assign full_w = (seq_len_q == LEN_W'(MAX_LEN));
    assign last_w = (LEN_W'(idx_q) == seq_len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tick_q    <= '0;
            seq_len_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tick_q    <= tick_d;
            seq_len_q <= seq_len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tick_d    = tick_q;
        seq_len_d = seq_len_q;
        wr_en     = 1'b0;
        if (bus.clear) begin
            state_d   = IDLE;
            idx_d     = '0;
            tick_d    = '0;
            seq_len_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) state_d = APPEND;
                end
                APPEND: begin
                    // A full sequence is replayed without growing.
                    if (!full_w) begin
                        wr_en     = 1'b1;
                        seq_len_d = seq_len_q + LEN_W'(1);
                    end
                    idx_d   = '0;
                    tick_d  = '0;
                    state_d = ON;
                end
                ON: begin
                    if (tick_q == TICK_W'(ON_TICKS - 1)) begin
                        tick_d  = '0;
                        state_d = OFF;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                OFF: begin
                    if (tick_q == TICK_W'(OFF_TICKS - 1)) begin
                        tick_d = '0;
                        if (last_w) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ON;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Storage needs no reset: entries at or beyond seq_len are never shown.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[seq_len_q[IDX_W-1:0]] <= lfsr_q[1:0];
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.colour_valid = (state_q == ON);
    assign bus.colour_out   = (state_q == ON) ? mem_q[idx_q] : COL_RED;
    assign bus.full         = full_w;
    assign bus.seq_len      = seq_len_q;
    assign bus.rd_colour    = (LEN_W'(bus.rd_idx) < seq_len_q) ? mem_q[bus.rd_idx] : COL_RED;

endmodule
